// File: rtl/sig_trace_buffer.sv
// rtl/sig_trace_buffer.sv - armed store-trace FIFO capturing signature or raw stores until halt
// Optional watchdog built when SIG_TRACE_WATCHDOG_EN is defined.
module sig_trace_buffer #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [ADDR_W-1:0] SIG_ADDR  = 32'h0000_0F00,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 32'hCAFE_BEEF,
    parameter int                TIMEOUT   = 5000,
    localparam int               PTR_W     = $clog2(DEPTH),
    localparam int               CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              mode,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              halted,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic halt_hit;
    logic wd_expire;
    logic push_req;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign halt_hit = (state_q == RUN) && st_valid && (st_addr == HALT_ADDR);
    assign push_req = (state_q == RUN) && st_valid && (st_addr != HALT_ADDR)
                      && (mode || (st_addr == SIG_ADDR));
    assign pop_ok   = rd_req && !empty;
    // A pop frees the slot the same cycle, so a full buffer can still accept a push.
    assign push_ok  = push_req && (!full || pop_ok);
    assign drop     = push_req && full && !pop_ok;

`ifdef SIG_TRACE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;

    // Halt takes priority when it lands on the expiry cycle.
    assign wd_expire = (state_q == RUN) && (wd == WD_W'(TIMEOUT - 1)) && !halt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_q == IDLE && arm) begin
                wd <= '0;
            end else if (state_q == RUN) begin
                wd <= wd + 1'b1;
            end
            if (wd_expire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = RUN;
            RUN:     if (halt_hit || wd_expire) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            halted   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (halt_hit) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sig_trace_buffer.sv
// tb/tb_sig_trace_buffer.sv - directed and random checks of sig_trace_buffer against a queue model
module tb_sig_trace_buffer;

    localparam int          DW      = 32;
    localparam int          AW      = 32;
    localparam int          DEPTH   = 4;
    localparam int          TIMEOUT = 10;
    localparam logic [31:0] SIG     = 32'h0000_0F00;
    localparam logic [31:0] HALT    = 32'hCAFE_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          mode;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          halted;
    logic          timeout;

    always #5 clk = ~clk;

    sig_trace_buffer #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .SIG_ADDR (SIG),
        .HALT_ADDR(HALT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .mode    (mode),
        .st_valid(st_valid),
        .st_addr (st_addr),
        .st_data (st_data),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .overflow(overflow),
        .halted  (halted),
        .timeout (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffer contents as a queue plus the run/done phase flags.
    logic [DW-1:0] mq[$];
    bit            m_run, m_done, m_ovf, m_halt, m_to, m_rv;
    logic [DW-1:0] m_rd;
    int            m_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit pop_ok;
        bit push;
        if (rst) begin
            mq.delete();
            m_run = 0; m_done = 0; m_ovf = 0; m_halt = 0; m_to = 0; m_rv = 0;
            m_rd = '0; m_wd = 0;
        end else begin
            pop_ok = rd_req && (mq.size() > 0);
            push   = m_run && st_valid && (st_addr != HALT) && (mode || st_addr == SIG);
            m_rv   = pop_ok;
            if (pop_ok) m_rd = mq.pop_front();
            if (push) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else mq.push_back(st_data);
            end
            if (!m_run && !m_done && arm) begin
                m_run = 1;
                m_wd  = 0;
            end else if (m_run) begin
                if (st_valid && st_addr == HALT) begin
                    m_run = 0; m_done = 1; m_halt = 1;
                end
`ifdef SIG_TRACE_WATCHDOG_EN
                else if (m_wd == TIMEOUT - 1) begin
                    m_run = 0; m_done = 1; m_to = 1;
                end else begin
                    m_wd++;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        chk("count",    64'(count),    64'(mq.size()));
        chk("empty",    64'(empty),    64'(mq.size() == 0));
        chk("full",     64'(full),     64'(mq.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("halted",   64'(halted),   64'(m_halt));
        chk("timeout",  64'(timeout),  64'(m_to));
        chk("rd_valid", 64'(rd_valid), 64'(m_rv));
        chk("rd_data",  64'(rd_data),  64'(m_rd));
    endtask

    task automatic idle_inputs();
        rst = 0; arm = 0; st_valid = 0; st_addr = '0; st_data = '0; rd_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic do_arm(input logic m);
        idle_inputs();
        mode = m;
        arm  = 1;
        step();
        arm = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic pop);
        st_valid = 1; st_addr = a; st_data = d; rd_req = pop;
        step();
        idle_inputs();
    endtask

    task automatic pop_one();
        idle_inputs();
        rd_req = 1;
        step();
        rd_req = 0;
    endtask

    initial begin
        int first_to;
        int r;
        idle_inputs();
        mode = 0;

        // Reset state, then rd_req on an empty buffer
        do_reset();
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        pop_one();
        chk("empty_pop_valid", 64'(rd_valid), 64'd0);

        // Signature capture with halt
        do_arm(1'b0);
        store(SIG, 32'h11, 0);
        store(SIG, 32'h22, 0);
        store(32'h100, 32'h33, 0);
        store(HALT, 32'h44, 0);
        chk("sig_count", 64'(count), 64'd2);
        chk("sig_halted", 64'(halted), 64'd1);
        store(SIG, 32'h55, 0);
        pop_one();
        chk("sig_pop0", 64'(rd_data), 64'h11);
        pop_one();
        chk("sig_pop1", 64'(rd_data), 64'h22);
        pop_one();

        // Raw trace overflow, then drain in order
        do_reset();
        do_arm(1'b1);
        for (int i = 1; i <= 6; i++) store(32'h100 + i, i, 0);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            pop_one();
            chk("ovf_pop", 64'(rd_data), 64'(i));
        end

        // Full buffer with simultaneous push and pop
        do_reset();
        do_arm(1'b1);
        for (int i = 0; i < 4; i++) store(32'h200, 32'hA0 + i, 0);
        store(32'h200, 32'hB0, 1);
        chk("fullpp_count", 64'(count), 64'd4);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        chk("fullpp_data", 64'(rd_data), 64'hA0);
        // Empty buffer with simultaneous push and pop: no bypass
        for (int i = 0; i < 4; i++) pop_one();
        store(32'h200, 32'hC0, 1);
        chk("emptypp_valid", 64'(rd_valid), 64'd0);
        chk("emptypp_count", 64'(count), 64'd1);

        // Watchdog
        do_reset();
        do_arm(1'b1);
        first_to = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (timeout && first_to < 0) first_to = i;
        end
`ifdef SIG_TRACE_WATCHDOG_EN
        chk("wd_cycle", 64'(first_to), 64'(TIMEOUT));
`else
        chk("wd_none", 64'(first_to), 64'hFFFF_FFFF_FFFF_FFFF);
        store(32'h300, 32'h77, 0);
        chk("wd_still_run", 64'(count), 64'd1);
`endif

        // Reset mid-RUN discards entries; later stores ignored until armed
        do_reset();
        do_arm(1'b1);
        for (int i = 0; i < 3; i++) store(SIG, 32'hD0 + i, 0);
        chk("midrun_count", 64'(count), 64'd3);
        do_reset();
        chk("midrun_rst_count", 64'(count), 64'd0);
        store(SIG, 32'hE0, 0);
        store(32'h100, 32'hE1, 0);
        chk("postrst_nocap", 64'(count), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom % 60) == 0;
            arm      = ($urandom % 8) == 0;
            mode     = $urandom % 2;
            st_valid = $urandom % 2;
            r        = $urandom % 20;
            st_addr  = (r < 8) ? SIG : (r < 16) ? 32'h100 : (r < 19) ? $urandom : HALT;
            st_data  = $urandom;
            rd_req   = ($urandom % 3) == 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
